// File: rtl/sub_box_pipe.sv
// Pipelined AES SubBytes / InvSubBytes unit, LANES bytes per word, stall-all valid/ready flow.
// Stage 0 registers the request; the S-box lookup sits between stage 0 and stage 1.
module sub_box_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int SUPPORT_INV = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [8*LANES-1:0]   reqData,
  input  logic                 reqInverse,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [8*LANES-1:0]   rspData,
  output logic                 rspInverse,
  output logic [1:0]           occupancy
);

  localparam int DW   = 8 * LANES;
  localparam int LAST = PIPE_STAGES - 1;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Tables are elaboration-time constants; the inverse one is pruned when mode is tied low.
  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  for (genvar g = 0; g < 256; g++) begin : g_tbl
    assign fwd_tbl[g] = fwd_sbox(8'(g));
    assign inv_tbl[g] = inv_sbox(8'(g));
  end

  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] mode_q;
  logic [DW-1:0]          data_q [PIPE_STAGES];
  logic                   advance;
  logic                   req_mode;
  logic                   look_mode;
  logic [DW-1:0]          look_src;
  logic [DW-1:0]          look_res;

  assign req_mode  = (SUPPORT_INV != 0) && reqInverse;
  assign advance   = !rspValid || rspReady;
  assign reqReady  = advance;
  assign look_src  = (PIPE_STAGES == 1) ? reqData  : data_q[0];
  assign look_mode = (PIPE_STAGES == 1) ? req_mode : mode_q[0];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign look_res[8*l +: 8] = look_mode ? inv_tbl[look_src[8*l +: 8]]
                                          : fwd_tbl[look_src[8*l +: 8]];
  end

  // Stage 0 loads the request; stage 1 loads the lookup; later stages are pure delay.
  // Data and mode only move with a valid word, so outputs stay put across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) data_q[s] <= '0;
    end else if (advance) begin
      vld_q[0] <= reqValid;
      if (reqValid) begin
        mode_q[0] <= req_mode;
        data_q[0] <= (PIPE_STAGES == 1) ? look_res : reqData;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          mode_q[s] <= mode_q[s-1];
          data_q[s] <= (s == 1) ? look_res : data_q[s-1];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int s = 0; s < PIPE_STAGES; s++) occupancy = occupancy + {1'b0, vld_q[s]};
  end

  assign rspValid   = vld_q[LAST];
  assign rspData    = data_q[LAST];
  assign rspInverse = mode_q[LAST];

endmodule

// File: tb/tb_sub_box_pipe.sv
// Scoreboarded bench for sub_box_pipe: main instance (4 lanes, 2 stages, inverse enabled)
// plus a 1-lane, 1-stage, forward-only instance.
module tb_sub_box_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        reqValid, reqReady, reqInverse;
  logic        rspValid, rspReady, rspInverse;
  logic [31:0] reqData, rspData;
  logic [1:0]  occupancy;

  logic        r1Valid, r1Ready, r1Inverse, s1Valid, s1Ready, s1Inverse;
  logic [7:0]  r1Data, s1Data;
  logic [1:0]  occ1;

  sub_box_pipe #(.LANES(4), .PIPE_STAGES(2), .SUPPORT_INV(1)) u_dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqData(reqData), .reqInverse(reqInverse),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspInverse(rspInverse),
    .occupancy(occupancy));

  sub_box_pipe #(.LANES(1), .PIPE_STAGES(1), .SUPPORT_INV(0)) u_fwd (
    .clk(clk), .reset(reset),
    .reqValid(r1Valid), .reqReady(r1Ready), .reqData(r1Data), .reqInverse(r1Inverse),
    .rspValid(s1Valid), .rspReady(s1Ready), .rspData(s1Data), .rspInverse(s1Inverse),
    .occupancy(occ1));

  typedef struct packed {
    logic [31:0] d;
    logic        m;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] t_fwd [256];
  logic [7:0] t_inv [256];
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  // Generator-3 walk: p runs over powers of 3, q over the matching inverses.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      t_fwd[p] = x ^ 8'h63;
    end while (p != 8'h01);
    t_fwd[0] = 8'h63;
    for (int i = 0; i < 256; i++) t_inv[t_fwd[i]] = 8'(i);
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic m);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = m ? t_inv[d[8*l +: 8]] : t_fwd[d[8*l +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the main instance; inputs must already be driven. Handles push/pop/stall.
  task automatic tick(input logic use_exp, input logic [31:0] exp_d);
    logic        acc, rel, stall;
    logic [31:0] held_d;
    logic        held_m;
    exp_t        e;
    #1;
    acc    = 1'b0;
    rel    = 1'b0;
    stall  = 1'b0;
    held_d = rspData;
    held_m = rspInverse;
    if (!reset) begin
      chk("reqReady", 32'(reqReady), 32'(!rspValid || rspReady));
      acc   = reqValid && reqReady;
      rel   = rspValid && rspReady;
      stall = rspValid && !rspReady;
      if (rel) begin
        chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rspData", rspData, e.d);
          chk("rspInverse", 32'(rspInverse), 32'(e.m));
        end
      end
      if (acc) begin
        e.d = use_exp ? exp_d : model(reqData, reqInverse);
        e.m = reqInverse;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (stall && !reset) begin
      chk("stall_valid", 32'(rspValid), 32'd1);
      chk("stall_data", rspData, held_d);
      chk("stall_mode", 32'(rspInverse), 32'(held_m));
    end
  endtask

  task automatic drain();
    reqValid = 1'b0;
    rspReady = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick(1'b0, 32'h0);
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    build_tables();
    reset = 1'b1; reqValid = 1'b0; reqData = '0; reqInverse = 1'b0; rspReady = 1'b0;
    r1Valid = 1'b0; r1Data = '0; r1Inverse = 1'b0; s1Ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_rspValid", 32'(rspValid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_rspData", rspData, 32'h0);
    chk("rst_rspInverse", 32'(rspInverse), 32'd0);
    chk("rst_fwd_rspValid", 32'(s1Valid), 32'd0);
    reset = 1'b0;

    // Forward vector and latency
    reqValid = 1'b1; reqData = 32'h0053ff01; reqInverse = 1'b0; rspReady = 1'b1;
    tick(1'b0, 32'h0);
    chk("t1_lat_not_yet", 32'(rspValid), 32'd0);
    chk("t1_occ", 32'(occupancy), 32'd1);
    reqValid = 1'b0;
    tick(1'b0, 32'h0);
    chk("t1_rspValid", 32'(rspValid), 32'd1);
    chk("t1_rspData", rspData, 32'h63ed167c);
    chk("t1_rspInverse", 32'(rspInverse), 32'd0);
    drain();

    // Inverse vector
    reqValid = 1'b1; reqData = 32'h63ed167c; reqInverse = 1'b1;
    tick(1'b0, 32'h0);
    reqValid = 1'b0;
    tick(1'b0, 32'h0);
    chk("t2_rspValid", 32'(rspValid), 32'd1);
    chk("t2_rspData", rspData, 32'h0053ff01);
    chk("t2_rspInverse", 32'(rspInverse), 32'd1);
    drain();

    // Exhaustive round trip at full throughput
    rspReady = 1'b1;
    for (int i = 0; i < 256; i++) begin
      reqValid = 1'b1; reqInverse = 1'b0;
      reqData = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      tick(1'b0, 32'h0);
      if (i >= 1) begin
        chk("t3_occ_full", 32'(occupancy), 32'd2);
        chk("t3_no_gap", 32'(rspValid), 32'd1);
      end
    end
    for (int i = 0; i < 256; i++) begin
      w = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      reqValid = 1'b1; reqInverse = 1'b1; reqData = model(w, 1'b0);
      tick(1'b1, w);
      chk("t3_inv_no_gap", 32'(rspValid), 32'd1);
    end
    drain();

    // Random back-pressure with alternating mode
    for (int i = 0; i < 300; i++) begin
      reqValid   = ($urandom_range(0, 3) != 0);
      reqData    = $urandom;
      reqInverse = i[0];
      rspReady   = ($urandom_range(0, 1) != 0);
      tick(1'b0, 32'h0);
    end
    drain();

    // Reset with the pipeline full
    reqValid = 1'b1; reqInverse = 1'b0; rspReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      reqData = $urandom;
      tick(1'b0, 32'h0);
    end
    chk("t5_occ_full", 32'(occupancy), 32'd2);
    chk("t5_stalled", 32'(reqReady), 32'd0);
    reset = 1'b1; reqValid = 1'b0;
    tick(1'b0, 32'h0);
    chk("t5_rst_rspValid", 32'(rspValid), 32'd0);
    chk("t5_rst_occ", 32'(occupancy), 32'd0);
    chk("t5_rst_rspData", rspData, 32'h0);
    sb.delete();
    reset = 1'b0;
    reqValid = 1'b1; reqData = 32'h00000053; reqInverse = 1'b0; rspReady = 1'b1;
    tick(1'b0, 32'h0);
    chk("t5_lat_not_yet", 32'(rspValid), 32'd0);
    reqValid = 1'b0;
    tick(1'b0, 32'h0);
    chk("t5_rspValid", 32'(rspValid), 32'd1);
    chk("t5_rspData", rspData, 32'h636363ed);
    drain();

    // Forward-only, single-stage instance
    r1Valid = 1'b1; r1Data = 8'h00; r1Inverse = 1'b1; s1Ready = 1'b1;
    #1;
    chk("t6_reqReady", 32'(r1Ready), 32'd1);
    @(posedge clk); #1;
    chk("t6_rspValid", 32'(s1Valid), 32'd1);
    chk("t6_rspData", 32'(s1Data), 32'h63);
    chk("t6_rspInverse", 32'(s1Inverse), 32'd0);
    chk("t6_occ", 32'(occ1), 32'd1);
    r1Data = 8'h53;
    @(posedge clk); #1;
    chk("t6_rspData_53", 32'(s1Data), 32'(t_fwd[8'h53]));
    r1Valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_empty", 32'(s1Valid), 32'd0);
    chk("t6_occ_empty", 32'(occ1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
